cpu_fetch: RTL
==============

# cpu_fetch

Instruction fetch stage of the Rv32H pipeline, directly upstream of the instruction cache and directly feeding decode. Owns the program counter and drives the cache's PC and stall inputs, holding the PC stable until the cache answers. Queues returned words in a 2-entry FIFO with a valid/ready handshake to decode. Applies branch/jump redirects from execute and discards any cache reply that is still in flight when a redirect arrives.

## Interface
- RESET_VECTOR, 32'h00000000, PC loaded at reset; must be word-aligned.
- i_clock  in  1  pipeline clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_redirect  in  1  execute requests a PC change this cycle.
- i_redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- o_icache_pc  out  32  fetch address to the cache; stable while a fetch is busy.
- o_icache_stall  out  1  low only in the cycle a new fetch is issued.
- i_icache_rdata  in  32  instruction word from the cache.
- i_icache_ready  in  1  single-cycle pulse that completes the current fetch.
- o_valid  out  1  FIFO head is valid for decode.
- i_ready  in  1  decode accepts the head this cycle.
- o_pc  out  32  PC of the head instruction.
- o_instruction  out  32  head instruction word.
- o_predicted  out  1  head was a JAL already followed by fetch.

## Operation
- Registers: next_pc, fetch_pc (drives o_icache_pc), busy, kill, and the 2-entry FIFO of {pc, instruction, predicted}.
- Issue condition: !busy && FIFO count < 2 && !i_redirect. o_icache_stall = !issue. On issue: busy <= 1, fetch_pc <= next_pc, next_pc <= next_pc + 4.
- On i_icache_ready with busy: busy <= 0. If kill is set, the word is dropped and kill <= 0. Otherwise {fetch_pc, i_icache_rdata, pred} is pushed.
- Redirect: FIFO flushed, next_pc <= i_redirect_pc. If busy and i_icache_ready is not asserted, kill <= 1. fetch_pc is not changed while busy.
- Redirect in the same cycle as i_icache_ready: the word is dropped and kill stays 0.
- Redirect in the same cycle as a decode pop: the flush wins. o_valid goes low the next cycle.
- Repeated redirects while kill is pending: the last target wins and kill remains 1.
- The FIFO never pushes when full, because issue requires count < 2 and at most one fetch is in flight.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.

## Timing
- Reset values:
  - o_valid 0, o_pc 0, o_instruction 0, o_predicted 0.
  - o_icache_pc = RESET_VECTOR, o_icache_stall 1.
  - busy 0, kill 0, FIFO empty.
  - next_pc = RESET_VECTOR.
- Reset mid-fetch aborts everything. The cache must be reset by the same i_reset.
- First issue occurs in the first clock cycle after i_reset deasserts.
- Fetch occupancy per instruction:
  - Cache hit: issue, then ready one cycle later.
  - Miss: ready follows after the bus latency.
  - The next issue happens in the cycle after ready, so hit throughput is 1 instruction per 2 cycles.
- A pushed word appears on o_valid the cycle after ready; the FIFO outputs are registered.
- A decode pop (o_valid && i_ready) takes effect at the clock edge. A simultaneous push and pop at count 1 keeps count 1.

## Configuration
- CPU_FETCH_JAL_PREDICT_EN defined:
  - On a non-killed ready with i_icache_rdata[6:0] == 7'b1101111, next_pc <= fetch_pc + sext(J-immediate).
  - The pushed entry carries predicted = 1; execute does not redirect for that JAL.
  - If no issue has occurred since that fetch's issue, this overrides the +4 already applied.
- Macro undefined:
  - next_pc advances by +4 only.
  - o_predicted is tied to 0.

## Structure
- Shared package: RV32 opcode constant OPCODE_JAL, J-immediate extraction function, and a typedef for the FIFO entry struct {pc, instruction, predicted}.
- One sub-module, cpu_fetch_fifo: a 2-entry synchronous FIFO with push, pop, flush, count, and registered head outputs. Flush takes priority over push and pop.

## Test plan
- Reset release with RESET_VECTOR = 32'h00000100 and a cache that always hits → decode receives PCs 0x100, 0x104, 0x108, …, one instruction every 2 cycles.
- Hold i_ready low → count reaches 2 and o_icache_stall stays 1. Raise i_ready → entries drain in order and fetch resumes at the next sequential PC.
- Redirect to 0x2000 while a miss is busy, then ready arrives with word 0xDEADBEEF → 0xDEADBEEF is never presented, and the next o_pc is 0x2000.
- Redirect in the same cycle as i_icache_ready and as a decode pop → FIFO empty the next cycle, kill = 0, and the next issue uses the redirect PC.
- With CPU_FETCH_JAL_PREDICT_EN, JAL with imm = -8 fetched at 0x40 → next o_pc is 0x38 with o_predicted = 1. Without the macro → next o_pc is 0x44 and o_predicted = 0.
- PC wrap: redirect to 0xFFFFFFFC → presented PCs 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and helpers for the cpu_fetch instruction fetch stage.
package cpu_fetch_pkg;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        predicted;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] j_imm(input logic [31:0] insn);
    return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Two-entry synchronous FIFO of fetched words; flush beats push and pop.
module cpu_fetch_fifo
  import cpu_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;
  logic [1:0]         cnt;

  // entry0 is always the head, so the outputs come straight from a register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) entry0 <= wdata;
          else             entry1 <= wdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            entry0 <= wdata;
          end else begin
            entry0 <= entry1;
            entry1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign count = cnt;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the PC, sequences icache requests, queues words for decode.
// Define CPU_FETCH_JAL_PREDICT_EN to follow JAL targets directly from fetch.
//
// state   | meaning
// ST_IDLE | no fetch outstanding; may issue
// ST_BUSY | fetch outstanding, reply will be queued
// ST_KILL | fetch outstanding, reply will be dropped (redirected)
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_icache_pc,
  output logic        o_icache_stall,
  input  logic [31:0] i_icache_rdata,
  input  logic        i_icache_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic        o_predicted
);

  fetch_state_t       state, state_nxt;
  logic [31:0]        next_pc;
  logic [31:0]        fetch_pc;
  logic [1:0]         count;
  logic               issue;
  logic               accept;
  logic               pop;
  logic               jal_hit;
  fetch_entry_t       wentry;
  fetch_entry_t       head;
  logic [ENTRY_W-1:0] head_bits;

  assign issue  = !i_reset && (state == ST_IDLE) && (count < 2'd2) && !i_redirect;
  assign accept = i_icache_ready && (state == ST_BUSY) && !i_redirect;
  assign pop    = o_valid && i_ready;

`ifdef CPU_FETCH_JAL_PREDICT_EN
  assign jal_hit = accept && (i_icache_rdata[6:0] == OPCODE_JAL);
`else
  assign jal_hit = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (i_icache_ready)  state_nxt = ST_IDLE;
        else if (i_redirect) state_nxt = ST_KILL;
      end
      ST_KILL: if (i_icache_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // a redirect outranks a JAL prediction from the same cycle's reply
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      next_pc  <= RESET_VECTOR;
      fetch_pc <= RESET_VECTOR;
    end else begin
      if (i_redirect) begin
        next_pc <= i_redirect_pc & 32'hFFFF_FFFC;
`ifdef CPU_FETCH_JAL_PREDICT_EN
      end else if (jal_hit) begin
        next_pc <= fetch_pc + j_imm(i_icache_rdata);
`endif
      end else if (issue) begin
        next_pc <= next_pc + 32'd4;
      end
      if (issue) fetch_pc <= next_pc;
    end
  end

  always_comb begin
    wentry             = '0;
    wentry.pc          = fetch_pc;
    wentry.instruction = i_icache_rdata;
    wentry.predicted   = jal_hit;
  end

  cpu_fetch_fifo u_fifo (
    .clock (i_clock),
    .reset (i_reset),
    .push  (accept),
    .pop   (pop),
    .flush (i_redirect),
    .wdata (wentry),
    .head  (head_bits),
    .count (count)
  );

  assign head           = fetch_entry_t'(head_bits);
  assign o_valid        = (count != 2'd0);
  assign o_pc           = head.pc;
  assign o_instruction  = head.instruction;
  assign o_predicted    = head.predicted;
  assign o_icache_pc    = fetch_pc;
  assign o_icache_stall = !issue;

endmodule
